mult_datapath: RTL and testbench

//  Register/arithmetic datapath for the 8-bit signed add-shift multiplier.

---
 rtl/mult_datapath_if.sv | 24 ++
 rtl/mult_datapath.sv | 50 +++++
 tb/tb_mult_datapath.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_datapath_if.sv
// Operation strobes and register taps shared by the multiplier control FSM and its datapath.
interface mult_datapath_if #(
  parameter int WIDTH = 8
);
  logic             Clr_Ld;
  logic             Shift;
  logic             Add;
  logic             Sub;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             X;
  logic             M;

  modport master (
    output Clr_Ld, Shift, Add, Sub, S,
    input  Aval, Bval, X, M
  );

  modport slave (
    input  Clr_Ld, Shift, Add, Sub, S,
    output Aval, Bval, X, M
  );
endinterface

// File: rtl/mult_datapath.sv
// Sign bit X, accumulator A and multiplier B for the signed add-shift multiplier.
// The product ends up in {A,B}; S is read live on each Clr_Ld/Add/Sub cycle.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic           Clk,
  input  logic           Reset_n,
  mult_datapath_if.slave bus
);

  logic             x_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   s_operand;
  logic [WIDTH:0]   sum9;

  // One WIDTH+1 bit adder serves both Add and Sub: Sub inverts S and supplies the carry-in.
  always_comb begin
    a_ext     = {a_reg[WIDTH-1], a_reg};
    s_operand = {bus.S[WIDTH-1], bus.S} ^ {(WIDTH+1){bus.Sub}};
    sum9      = a_ext + s_operand + {{WIDTH{1'b0}}, bus.Sub};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_reg <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
    end else if (bus.Clr_Ld) begin
      x_reg <= 1'b0;
      a_reg <= '0;
      b_reg <= bus.S;
    end else if (bus.Sub || bus.Add) begin
      x_reg <= sum9[WIDTH];
      a_reg <= sum9[WIDTH-1:0];
    end else if (bus.Shift) begin
      // X is replicated into A rather than shifted, so the sign persists across all shifts.
      a_reg <= {x_reg, a_reg[WIDTH-1:1]};
      b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
    end
  end

  assign bus.Aval = a_reg;
  assign bus.Bval = b_reg;
  assign bus.X    = x_reg;
  assign bus.M    = b_reg[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Directed checks of load, add, subtract, shift, priority, reset and full multiplies.
module tb_mult_datapath;

  logic Clk;
  logic Reset_n;
  int   check_count;
  int   pass_count;

  mult_datapath_if #(.WIDTH(8)) bus ();

  mult_datapath #(.WIDTH(8)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Ops are driven at a falling edge, take effect on the following rising edge, and are
  // sampled at the next falling edge.
  task automatic apply_op(input logic clr, input logic sub, input logic add,
                          input logic shft, input logic [7:0] s_val);
    @(negedge Clk);
    bus.Clr_Ld = clr;
    bus.Sub    = sub;
    bus.Add    = add;
    bus.Shift  = shft;
    bus.S      = s_val;
    @(negedge Clk);
    bus.Clr_Ld = 1'b0;
    bus.Sub    = 1'b0;
    bus.Add    = 1'b0;
    bus.Shift  = 1'b0;
  endtask

  task automatic run_multiply(input logic [7:0] b_val, input logic [7:0] s_val,
                              output logic [15:0] prod);
    apply_op(1'b1, 1'b0, 1'b0, 1'b0, b_val);
    for (int i = 0; i < 8; i++) begin
      if (bus.M)
        apply_op(1'b0, (i == 7), (i != 7), 1'b0, s_val);
      apply_op(1'b0, 1'b0, 1'b0, 1'b1, s_val);
    end
    prod = {bus.Aval, bus.Bval};
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    check_count++;
    if ({bus.X, bus.Aval, bus.Bval, bus.M} !== 18'h0)
      $display("[TB] FAIL reset_init: got X=%b A=%h B=%h M=%b expected all 0",
               bus.X, bus.Aval, bus.Bval, bus.M);
    else pass_count++;
    Reset_n = 1'b1;
  endtask

  task automatic test_load();
    apply_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
    check_count++;
    if ({bus.X, bus.Aval, bus.Bval, bus.M} !== {1'b0, 8'h00, 8'h07, 1'b1})
      $display("[TB] FAIL load: got X=%b A=%h B=%h M=%b expected X=0 A=00 B=07 M=1",
               bus.X, bus.Aval, bus.Bval, bus.M);
    else pass_count++;
  endtask

  task automatic test_add_shift();
    apply_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    check_count++;
    if ({bus.X, bus.Aval, bus.Bval} !== {1'b0, 8'h05, 8'h07})
      $display("[TB] FAIL add: got X=%b A=%h B=%h expected X=0 A=05 B=07",
               bus.X, bus.Aval, bus.Bval);
    else pass_count++;
    apply_op(1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
    check_count++;
    if ({bus.X, bus.Aval, bus.Bval, bus.M} !== {1'b0, 8'h02, 8'h83, 1'b1})
      $display("[TB] FAIL add_shift: got X=%b A=%h B=%h M=%b expected X=0 A=02 B=83 M=1",
               bus.X, bus.Aval, bus.Bval, bus.M);
    else pass_count++;
    // Idle cycle must hold everything.
    @(negedge Clk);
    check_count++;
    if ({bus.X, bus.Aval, bus.Bval} !== {1'b0, 8'h02, 8'h83})
      $display("[TB] FAIL hold: got X=%b A=%h B=%h expected X=0 A=02 B=83",
               bus.X, bus.Aval, bus.Bval);
    else pass_count++;
  endtask

  task automatic test_sub_sign();
    apply_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    apply_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h05);
    check_count++;
    if ({bus.X, bus.Aval} !== {1'b1, 8'hFB})
      $display("[TB] FAIL sub: got X=%b A=%h expected X=1 A=fb", bus.X, bus.Aval);
    else pass_count++;
    apply_op(1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
    check_count++;
    if ({bus.X, bus.Aval, bus.Bval, bus.M} !== {1'b1, 8'hFD, 8'h80, 1'b0})
      $display("[TB] FAIL sub_shift: got X=%b A=%h B=%h M=%b expected X=1 A=fd B=80 M=0",
               bus.X, bus.Aval, bus.Bval, bus.M);
    else pass_count++;
  endtask

  task automatic test_priority();
    apply_op(1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
    check_count++;
    if ({bus.X, bus.Aval, bus.Bval} !== {1'b0, 8'h00, 8'h11})
      $display("[TB] FAIL prio_load_add: got X=%b A=%h B=%h expected X=0 A=00 B=11",
               bus.X, bus.Aval, bus.Bval);
    else pass_count++;
    apply_op(1'b0, 1'b0, 1'b1, 1'b1, 8'h03);
    check_count++;
    if ({bus.X, bus.Aval, bus.Bval} !== {1'b0, 8'h03, 8'h11})
      $display("[TB] FAIL prio_add_shift: got X=%b A=%h B=%h expected X=0 A=03 B=11",
               bus.X, bus.Aval, bus.Bval);
    else pass_count++;
    apply_op(1'b0, 1'b1, 1'b1, 1'b0, 8'h01);
    check_count++;
    if ({bus.X, bus.Aval, bus.Bval} !== {1'b0, 8'h02, 8'h11})
      $display("[TB] FAIL prio_sub_add: got X=%b A=%h B=%h expected X=0 A=02 B=11",
               bus.X, bus.Aval, bus.Bval);
    else pass_count++;
  endtask

  task automatic test_multiply();
    logic [15:0] prod;
    run_multiply(8'h07, 8'hFD, prod);
    check_count++;
    if (prod !== 16'hFFEB)
      $display("[TB] FAIL mul_07_fd: got %h expected ffeb", prod);
    else pass_count++;
    run_multiply(8'hFD, 8'hFD, prod);
    check_count++;
    if (prod !== 16'h0009)
      $display("[TB] FAIL mul_fd_fd: got %h expected 0009", prod);
    else pass_count++;
    run_multiply(8'h80, 8'h80, prod);
    check_count++;
    if (prod !== 16'h4000)
      $display("[TB] FAIL mul_80_80: got %h expected 4000", prod);
    else pass_count++;
    run_multiply(8'h03, 8'h04, prod);
    check_count++;
    if (prod !== 16'h000C)
      $display("[TB] FAIL mul_03_04: got %h expected 000c", prod);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    apply_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    apply_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
    check_count++;
    if (bus.Aval !== 8'h3C)
      $display("[TB] FAIL pre_reset_a: got %h expected 3c", bus.Aval);
    else pass_count++;
    // Reset asserted between edges must clear state without waiting for a clock.
    #2;
    Reset_n  = 1'b0;
    bus.Add  = 1'b1;
    bus.S    = 8'h22;
    #1;
    check_count++;
    if ({bus.X, bus.Aval, bus.Bval, bus.M} !== 18'h0)
      $display("[TB] FAIL async_reset: got X=%b A=%h B=%h M=%b expected all 0",
               bus.X, bus.Aval, bus.Bval, bus.M);
    else pass_count++;
    @(posedge Clk);
    #1;
    check_count++;
    if ({bus.X, bus.Aval, bus.Bval} !== 17'h0)
      $display("[TB] FAIL reset_hold: got X=%b A=%h B=%h expected all 0",
               bus.X, bus.Aval, bus.Bval);
    else pass_count++;
    @(negedge Clk);
    bus.Add = 1'b0;
    Reset_n = 1'b1;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    bus.Clr_Ld  = 1'b0;
    bus.Shift   = 1'b0;
    bus.Add     = 1'b0;
    bus.Sub     = 1'b0;
    bus.S       = 8'h00;
    Reset_n     = 1'b0;

    test_reset();
    test_load();
    test_add_shift();
    test_sub_sign();
    test_priority();
    test_multiply();
    test_back_to_back();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
